// File: rtl/led_sequencer.sv
// Stepped LED pattern engine for the Alhambra-II 8-LED bank.
// A debounced push-button cycles BLINK -> RUN -> BOUNCE -> COUNT -> BLINK.
module led_sequencer #(
   parameter int unsigned DIV      = 1500000,
   parameter int unsigned DEBOUNCE = 120000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SW1,
   output logic [7:0] LED,
   output logic [1:0] MODE,
   output logic       STEP
);

   localparam int unsigned PW = $clog2(DIV);
   localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);

   localparam logic [1:0] MODE_BLINK  = 2'd0;
   localparam logic [1:0] MODE_RUN    = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_COUNT  = 2'd3;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    mode_q, mode_d;
   logic [7:0]    led_q, led_d;
   logic          phase_q, phase_d;
   logic          dir_q, dir_d;

   logic press;
   logic step_now;
   logic advance;

   // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      sync1_d  = SW1;
      sync2_d  = sync1_q;
      deb_d    = deb_q;
      cnt_d    = '0;
      press    = 1'b0;
      presc_d  = '0;
      mode_d   = mode_q;
      led_d    = led_q;
      phase_d  = phase_q;
      dir_d    = dir_q;

      // The flip is the press itself, so MODE changes on the same edge as the debounced level.
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            press = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      step_now = (presc_q == PRESC_LAST);
      advance  = step_now && !press;
      if (!step_now) presc_d = presc_q + PW'(1);

      if (press) begin
         mode_d  = mode_q + 2'd1;
         presc_d = '0;
         phase_d = 1'b0;
         dir_d   = DIR_LEFT;
         led_d   = (mode_d == MODE_RUN || mode_d == MODE_BOUNCE) ? 8'h01 : 8'h00;
      end else if (advance) begin
         case (mode_q)
            MODE_BLINK: begin
               phase_d = ~phase_q;
               led_d   = phase_d ? 8'hFF : 8'h00;
            end
            MODE_RUN: led_d = {led_q[6:0], led_q[7]};
            MODE_BOUNCE: begin
               if (dir_q == DIR_LEFT) begin
                  if (led_q == 8'h80) begin
                     dir_d = DIR_RIGHT;
                     led_d = 8'h40;
                  end else begin
                     led_d = led_q << 1;
                  end
               end else begin
                  if (led_q == 8'h01) begin
                     dir_d = DIR_LEFT;
                     led_d = 8'h02;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
            MODE_COUNT: led_d = led_q + 8'd1;
            default:    led_d = led_q;
         endcase
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         presc_q <= '0;
         mode_q  <= MODE_BLINK;
         led_q   <= 8'h00;
         phase_q <= 1'b0;
         dir_q   <= DIR_LEFT;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         mode_q  <= mode_d;
         led_q   <= led_d;
         phase_q <= phase_d;
         dir_q   <= dir_d;
      end
   end

   assign LED  = led_q;
   assign MODE = mode_q;
   assign STEP = step_now;

endmodule
